// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port sync RAM between the CPU data port (0)
// and the SPI programmer port (1), with a bounded burst lock and registered RAM drive.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADD_WIDTH  = 6,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic                  m0_we,
    input  logic [ADD_WIDTH-1:0]  m0_add,
    input  logic [DATA_WIDTH-1:0] m0_din,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic                  m1_we,
    input  logic [ADD_WIDTH-1:0]  m1_add,
    input  logic [DATA_WIDTH-1:0] m1_din,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_we,
    output logic [ADD_WIDTH-1:0]  ram_add,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [1:0]            owner
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    // State encoding doubles as the owner code driven on the owner port.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_next;
    logic             last_win;
    logic             last_next;
    logic             win_lock;

    logic                  we_p1;
    logic [ADD_WIDTH-1:0]  add_p1;
    logic [DATA_WIDTH-1:0] din_p1;
    logic                  vld0_p2;
    logic                  vld1_p2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= BURST_MAX) ? BURST_MAX : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last_win  <= 1'b1;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_next;
            last_win  <= last_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (m0_req && m1_req) begin
            if (state == OWN0 && m0_lock && burst_cnt < BURST_MAX) begin
                state_next = OWN0;
            end else if (state == OWN1 && m1_lock && burst_cnt < BURST_MAX) begin
                state_next = OWN1;
            end else begin
                // last_win=1 means port 1 was served last, so port 0 is due.
                state_next = last_win ? OWN0 : OWN1;
            end
        end else if (m0_req) begin
            state_next = OWN0;
        end else if (m1_req) begin
            state_next = OWN1;
        end
    end

    always_comb begin
        burst_next = '0;
        last_next  = last_win;
        win_lock   = 1'b0;
        case (state_next)
            OWN0: begin
                win_lock  = m0_lock;
                last_next = 1'b0;
            end
            OWN1: begin
                win_lock  = m1_lock;
                last_next = 1'b1;
            end
            default: begin
                win_lock  = 1'b0;
                last_next = last_win;
            end
        endcase
        if (state_next == IDLE) begin
            burst_next = '0;
        end else if (state_next == state && win_lock) begin
            burst_next = sat_inc(burst_cnt);
        end else begin
            burst_next = CNT_W'(1);
        end
    end

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        owner  = state;
        case (state)
            OWN0:    m0_gnt = 1'b1;
            OWN1:    m1_gnt = 1'b1;
            default: owner  = IDLE;
        endcase
    end

    // p1: registered RAM command for the access granted at this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            we_p1  <= 1'b0;
            add_p1 <= '0;
            din_p1 <= '0;
        end else begin
            case (state_next)
                OWN0: begin
                    we_p1  <= m0_we;
                    add_p1 <= m0_add;
                    din_p1 <= m0_din;
                end
                OWN1: begin
                    we_p1  <= m1_we;
                    add_p1 <= m1_add;
                    din_p1 <= m1_din;
                end
                default: we_p1 <= 1'b0;
            endcase
        end
    end

    // p2: the RAM has registered read data; flag which port it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            vld0_p2 <= 1'b0;
            vld1_p2 <= 1'b0;
        end else begin
            vld0_p2 <= (state == OWN0) && !we_p1;
            vld1_p2 <= (state == OWN1) && !we_p1;
        end
    end

    assign ram_we    = we_p1;
    assign ram_add   = add_p1;
    assign ram_din   = din_p1;
    assign m0_rvalid = vld0_p2;
    assign m1_rvalid = vld1_p2;
    assign rdata     = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level arbitration and memory model.
module tb_ram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_req, m0_lock, m0_we;
    logic [AW-1:0] m0_add;
    logic [DW-1:0] m0_din;
    logic          m1_req, m1_lock, m1_we;
    logic [AW-1:0] m1_add;
    logic [DW-1:0] m1_din;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [1:0]    owner;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_add(m0_add), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_add(m1_add), .m1_din(m1_din),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .ram_we(ram_we), .ram_add(ram_add), .ram_din(ram_din),
        .ram_dout(ram_dout), .owner(owner)
    );

    // Stand-in for sync_ram: registered output, write data forwarded on a write.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_add] <= ram_din;
        ram_dout <= ram_we ? ram_din : ram_mem[ram_add];
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model: who holds the RAM this cycle and what response is due.
    logic [DW-1:0] mref [0:(1<<AW)-1] = '{default: '0};
    int            cur_port  = -1;
    logic          cur_we    = 1'b0;
    logic [AW-1:0] cur_add   = '0;
    logic [DW-1:0] cur_din   = '0;
    int            cnt       = 0;
    int            last      = 1;
    int            resp_port = -1;
    logic [DW-1:0] resp_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic          r [2];
        logic          l [2];
        logic          w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int            win;
        r[0] = m0_req;  l[0] = m0_lock; w[0] = m0_we; a[0] = m0_add; d[0] = m0_din;
        r[1] = m1_req;  l[1] = m1_lock; w[1] = m1_we; a[1] = m1_add; d[1] = m1_din;
        resp_port = -1;
        if (cur_port >= 0) begin
            if (cur_we) mref[cur_add] = cur_din;
            else begin
                resp_port = cur_port;
                resp_data = mref[cur_add];
            end
        end
        if (rst) begin
            resp_port = -1;
            cur_port  = -1;
            cur_we    = 1'b0;
            cur_add   = '0;
            cur_din   = '0;
            cnt       = 0;
            last      = 1;
            return;
        end
        if (!r[0] && !r[1]) win = -1;
        else if (r[0] != r[1]) win = r[0] ? 0 : 1;
        else if (cur_port >= 0 && l[cur_port] && cnt < MB) win = cur_port;
        else win = 1 - last;
        if (win < 0) cnt = 0;
        else if (win == cur_port && l[win]) cnt = (cnt < MB) ? cnt + 1 : MB;
        else cnt = 1;
        if (win >= 0) begin
            last    = win;
            cur_we  = w[win];
            cur_add = a[win];
            cur_din = d[win];
        end else begin
            cur_we = 1'b0;
        end
        cur_port = win;
    endtask

    task automatic compare_all();
        chk("owner", 32'(owner), (cur_port < 0) ? 32'd0 : ((cur_port == 0) ? 32'd1 : 32'd2));
        chk("gnt0", 32'(m0_gnt), 32'(cur_port == 0));
        chk("gnt1", 32'(m1_gnt), 32'(cur_port == 1));
        chk("ram_we", 32'(ram_we), 32'(cur_we));
        if (cur_port >= 0) chk("ram_add", 32'(ram_add), 32'(cur_add));
        if (cur_we) chk("ram_din", 32'(ram_din), 32'(cur_din));
        chk("rvalid0", 32'(m0_rvalid), 32'(resp_port == 0));
        chk("rvalid1", 32'(m1_rvalid), 32'(resp_port == 1));
        if (resp_port >= 0) chk("rdata", 32'(rdata), 32'(resp_data));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [AW-1:0] rnd_add();
        return ($urandom_range(0, 4) == 0) ? AW'(63) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        int  exp4 [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        bit  seen_g;
        bit  done;

        rst = 1'b1;
        m0_req = 1'b1; m0_lock = 1'b0; m0_we = 1'b0; m0_add = '0; m0_din = '0;
        m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b0; m1_add = '0; m1_din = '0;

        // Reset held with both ports requesting
        tick();
        tick();
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        rst = 1'b0;
        tick();
        chk("first_gnt0", 32'(m0_gnt), 32'd1);
        chk("first_gnt1", 32'(m1_gnt), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Single write then read on port 0
        m0_req = 1'b1; m0_we = 1'b1; m0_add = AW'(5); m0_din = 16'hBEEF;
        tick();
        chk("wr_gnt0", 32'(m0_gnt), 32'd1);
        chk("wr_we", 32'(ram_we), 32'd1);
        chk("wr_add", 32'(ram_add), 32'd5);
        m0_we = 1'b0;
        tick();
        chk("rd_gnt0", 32'(m0_gnt), 32'd1);
        m0_req = 1'b0;
        tick();
        chk("rd_rvalid0", 32'(m0_rvalid), 32'd1);
        chk("rd_data", 32'(rdata), 32'h0000BEEF);
        chk("rd_rvalid1", 32'(m1_rvalid), 32'd0);
        tick();

        // Contention without lock alternates; port 1 is due first
        m0_req = 1'b1; m0_add = AW'(1);
        m1_req = 1'b1; m1_we = 1'b0; m1_add = AW'(2);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alt_gnt0", 32'(m0_gnt), 32'(i % 2));
            chk("alt_onehot", 32'(m0_gnt ^ m1_gnt), 32'd1);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();

        // Burst lock on port 0
        m0_req = 1'b1; m0_lock = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("burst_gnt1", 32'(m1_gnt), 32'(exp4[i]));
        end
        m1_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("sole_gnt0", 32'(m0_gnt), 32'd1);
        end
        m0_req = 1'b0; m0_lock = 1'b0;
        tick();
        tick();

        // SPI patch of address 63 while port 0 streams reads of it
        m0_req = 1'b1; m0_we = 1'b0; m0_add = AW'(63);
        tick();
        tick();
        tick();
        m1_req = 1'b1; m1_we = 1'b1; m1_add = AW'(63); m1_din = 16'h1234;
        seen_g = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m1_gnt && !seen_g) begin
                seen_g = 1'b1;
                m1_req = 1'b0;
            end else if (seen_g && !done && m0_rvalid) begin
                chk("patch_rdata", 32'(rdata), 32'h00001234);
                done = 1'b1;
            end
        end
        chk("patch_seen", 32'(done), 32'd1);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();

        // Reset lands on the edge closing a port 1 read grant
        m1_req = 1'b1; m1_we = 1'b0; m1_add = AW'(63);
        tick();
        chk("rstrd_gnt1", 32'(m1_gnt), 32'd1);
        rst = 1'b1; m1_req = 1'b0;
        tick();
        chk("rstrd_rvalid1", 32'(m1_rvalid), 32'd0);
        chk("rstrd_we", 32'(ram_we), 32'd0);
        chk("rstrd_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        tick();

        // A write already on the RAM pins survives a reset at its closing edge
        m0_req = 1'b1; m0_we = 1'b1; m0_add = AW'(9); m0_din = 16'h5A5A;
        tick();
        rst = 1'b1; m0_req = 1'b0;
        tick();
        rst = 1'b0; m0_req = 1'b1; m0_we = 1'b0;
        tick();
        m0_req = 1'b0;
        tick();
        chk("keepwr_rvalid0", 32'(m0_rvalid), 32'd1);
        chk("keepwr_rdata", 32'(rdata), 32'h00005A5A);
        tick();

        // Random traffic: requests are held until granted
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!m0_req || m0_gnt) begin
                m0_req  = ($urandom_range(0, 3) != 0);
                m0_lock = 1'($urandom_range(0, 1));
                m0_we   = ($urandom_range(0, 2) == 0);
                m0_add  = rnd_add();
                m0_din  = DW'($urandom);
            end
            if (!m1_req || m1_gnt) begin
                m1_req  = ($urandom_range(0, 3) != 0);
                m1_lock = 1'($urandom_range(0, 1));
                m1_we   = ($urandom_range(0, 2) == 0);
                m1_add  = rnd_add();
                m1_din  = DW'($urandom);
            end
            tick();
            chk("rv_excl", 32'(m0_rvalid & m1_rvalid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
